// File: rtl/cpu_pkg.sv
// Shared opcode, bus-select index and sequencer state definitions.
// Pure declarations; no logic, no latency, no flow control.
package cpu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  // Bus source indices; R0..R15 occupy 0..15.
  localparam int BUS_R0     = 0;
  localparam int BUS_HI     = 16;
  localparam int BUS_LO     = 17;
  localparam int BUS_ZHI    = 18;
  localparam int BUS_ZLO    = 19;
  localparam int BUS_PC     = 20;
  localparam int BUS_MDR    = 21;
  localparam int BUS_INPORT = 22;
  localparam int BUS_C      = 23;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_ILLEGAL
  } state_t;

endpackage

// File: rtl/ir_field_decode.sv
// Splits an instruction word into opcode/register fields and classifies the opcode.
// Purely combinational, zero latency, no flow control.
module ir_field_decode (
  input  logic [31:0] ir,
  output logic [4:0]  opcode,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [3:0]  rc,
  output logic        is_muldiv,
  output logic        is_unary,
  output logic        is_legal
);
  import cpu_pkg::*;

  assign opcode    = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];

  assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign is_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);
  assign is_legal  = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
                                    OP_SHR, OP_SHRA, OP_SHL, OP_DIV, OP_MUL,
                                    OP_NEG, OP_NOT};

endmodule

// File: rtl/alu_instr_sequencer.sv
// Moore control-step sequencer: fetch T0-T2, execute T3-T5/T6 for one ALU instruction.
// done 6 cycles after start (7 for mul/div), +1 per mem_ready=0 cycle in T1; start ignored while busy.
module alu_instr_sequencer #(
  parameter int NUM_GPR = 16,
  parameter int SEL_W   = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [31:0]        ir,
  input  logic               mem_ready,
  output logic [SEL_W-1:0]   bus_sel,
  output logic [NUM_GPR-1:0] gpr_in,
  output logic               pc_in,
  output logic               ir_in,
  output logic               mar_in,
  output logic               mdr_in,
  output logic               y_in,
  output logic               z_in,
  output logic               hi_in,
  output logic               lo_in,
  output logic               inc_pc,
  output logic               read,
  output logic [4:0]         alu_op,
  output logic               busy,
  output logic               done,
  output logic               illegal
);
  import cpu_pkg::*;

  state_t     state;
  state_t     state_nxt;
  logic [4:0] opcode;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       is_muldiv;
  logic       is_unary;
  logic       is_legal;

  ir_field_decode u_dec (
    .ir        (ir),
    .opcode    (opcode),
    .ra        (ra),
    .rb        (rb),
    .rc        (rc),
    .is_muldiv (is_muldiv),
    .is_unary  (is_unary),
    .is_legal  (is_legal)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  assign busy = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    bus_sel   = '0;
    gpr_in    = '0;
    pc_in     = 1'b0;
    ir_in     = 1'b0;
    mar_in    = 1'b0;
    mdr_in    = 1'b0;
    y_in      = 1'b0;
    z_in      = 1'b0;
    hi_in     = 1'b0;
    lo_in     = 1'b0;
    inc_pc    = 1'b0;
    read      = 1'b0;
    alu_op    = '0;
    done      = 1'b0;
    illegal   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_T0;
      end
      S_T0: begin
        bus_sel[BUS_PC] = 1'b1;
        mar_in          = 1'b1;
        inc_pc          = 1'b1;
        z_in            = 1'b1;
        state_nxt       = S_T1;
      end
      S_T1: begin
        // PC and MDR load only on the exit cycle so a memory stall loads PC once.
        bus_sel[BUS_ZLO] = 1'b1;
        read             = 1'b1;
        pc_in            = mem_ready;
        mdr_in           = mem_ready;
        if (mem_ready) state_nxt = S_T2;
      end
      S_T2: begin
        bus_sel[BUS_MDR] = 1'b1;
        ir_in            = 1'b1;
        state_nxt        = is_legal ? S_T3 : S_ILLEGAL;
      end
      S_T3: begin
        if (!is_unary) begin
          bus_sel[rb] = 1'b1;
          y_in        = 1'b1;
        end
        state_nxt = S_T4;
      end
      S_T4: begin
        bus_sel[is_unary ? rb : rc] = 1'b1;
        alu_op                      = opcode;
        z_in                        = 1'b1;
        state_nxt                   = S_T5;
      end
      S_T5: begin
        bus_sel[BUS_ZLO] = 1'b1;
        if (is_muldiv) begin
          lo_in     = 1'b1;
          state_nxt = S_T6;
        end else begin
          gpr_in[ra] = 1'b1;
          done       = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      S_T6: begin
        bus_sel[BUS_ZHI] = 1'b1;
        hi_in            = 1'b1;
        done             = 1'b1;
        state_nxt        = S_IDLE;
      end
      S_ILLEGAL: begin
        done      = 1'b1;
        illegal   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Randomized bench: a step-list model of each instruction predicts every cycle's control word.
module tb_alu_instr_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] ir;
  logic        mem_ready;
  logic [31:0] bus_sel;
  logic [15:0] gpr_in;
  logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc, read;
  logic [4:0]  alu_op;
  logic        busy, done, illegal;

  always #5 clock = ~clock;

  alu_instr_sequencer #(.NUM_GPR(16), .SEL_W(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .ir        (ir),
    .mem_ready (mem_ready),
    .bus_sel   (bus_sel),
    .gpr_in    (gpr_in),
    .pc_in     (pc_in),
    .ir_in     (ir_in),
    .mar_in    (mar_in),
    .mdr_in    (mdr_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .hi_in     (hi_in),
    .lo_in     (lo_in),
    .inc_pc    (inc_pc),
    .read      (read),
    .alu_op    (alu_op),
    .busy      (busy),
    .done      (done),
    .illegal   (illegal)
  );

  typedef struct packed {
    logic [31:0] bus_sel;
    logic [15:0] gpr_in;
    logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc, read;
    logic [4:0]  alu_op;
    logic        busy, done, illegal;
  } ctl_t;

  ctl_t exp_q[$];
  ctl_t seq[$];
  int   mrq[$];   // mem_ready per step: 0/1 forced, 2 = free
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  ctl_t cmp_exp;
  ctl_t cmp_act;

  // Single compare process: every driven cycle has exactly one expected word.
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      cmp_exp = exp_q.pop_front();
      cmp_act = {bus_sel, gpr_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in,
                 inc_pc, read, alu_op, busy, done, illegal};
      n_checks++;
      if (cmp_act !== cmp_exp) begin
        n_fail++;
        $display("FAIL ctl_cycle_%0d: got %h expected %h", cyc, cmp_act, cmp_exp);
      end
      cyc++;
    end
  end

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Model: the list of per-cycle control words one instruction must produce.
  task automatic build(input logic [31:0] iw, input int w);
    ctl_t       c;
    logic [4:0] op = iw[31:27];
    logic [3:0] ra = iw[26:23];
    logic [3:0] rb = iw[22:19];
    logic [3:0] rc = iw[18:15];
    bit legal  = op inside {[5'd3:5'd11], 5'd15, 5'd16, 5'd17, 5'd18};
    bit muldiv = (op == 5'd15) || (op == 5'd16);
    bit unary  = (op == 5'd17) || (op == 5'd18);
    seq.delete();
    mrq.delete();
    c = '0; c.busy = 1; c.bus_sel = 32'h1 << 20; c.mar_in = 1; c.inc_pc = 1; c.z_in = 1;
    seq.push_back(c); mrq.push_back(2);
    for (int i = 0; i < w; i++) begin
      c = '0; c.busy = 1; c.bus_sel = 32'h1 << 19; c.read = 1;
      seq.push_back(c); mrq.push_back(0);
    end
    c = '0; c.busy = 1; c.bus_sel = 32'h1 << 19; c.read = 1; c.pc_in = 1; c.mdr_in = 1;
    seq.push_back(c); mrq.push_back(1);
    c = '0; c.busy = 1; c.bus_sel = 32'h1 << 21; c.ir_in = 1;
    seq.push_back(c); mrq.push_back(2);
    if (!legal) begin
      c = '0; c.busy = 1; c.done = 1; c.illegal = 1;
      seq.push_back(c); mrq.push_back(2);
      return;
    end
    c = '0; c.busy = 1;
    if (!unary) begin c.bus_sel = 32'h1 << rb; c.y_in = 1; end
    seq.push_back(c); mrq.push_back(2);
    c = '0; c.busy = 1; c.bus_sel = 32'h1 << (unary ? rb : rc); c.alu_op = op; c.z_in = 1;
    seq.push_back(c); mrq.push_back(2);
    c = '0; c.busy = 1; c.bus_sel = 32'h1 << 19;
    if (muldiv) c.lo_in = 1;
    else begin c.gpr_in = 16'h1 << ra; c.done = 1; end
    seq.push_back(c); mrq.push_back(2);
    if (muldiv) begin
      c = '0; c.busy = 1; c.bus_sel = 32'h1 << 18; c.hi_in = 1; c.done = 1;
      seq.push_back(c); mrq.push_back(2);
    end
  endtask

  task automatic step(input logic st, input logic mr, input logic rn, input ctl_t e);
    @(posedge clock);
    #1;
    start     = st;
    mem_ready = mr;
    reset_n   = rn;
    exp_q.push_back(e);
  endtask

  // Issue one instruction; abort >= 0 pulls reset_n low during that step.
  task automatic run_instr(input logic [31:0] iw, input int w, input bit noise, input int abort);
    logic mr;
    ir = iw;
    build(iw, w);
    step(1'b1, 1'($urandom % 2), 1'b1, '0);
    for (int i = 0; i < seq.size(); i++) begin
      mr = (mrq[i] == 2) ? 1'($urandom % 2) : 1'(mrq[i]);
      if (i == abort || (abort >= seq.size() && i == seq.size() - 1)) begin
        step(noise, mr, 1'b0, seq[i]);
        step(1'b0, mr, 1'b1, '0);
        return;
      end
      step(noise, mr, 1'b1, seq[i]);
    end
    step(1'b0, 1'($urandom % 2), 1'b1, '0);
  endtask

  logic [4:0] legal_ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                                 5'd15, 5'd16, 5'd17, 5'd18};

  initial begin
    logic [31:0] add_ir;
    logic [31:0] want_bus [6];
    logic [4:0]  op;
    reset_n   = 1'b0;
    start     = 1'b0;
    mem_ready = 1'b0;
    ir        = '0;
    add_ir    = {5'd3, 4'd3, 4'd1, 4'd2, 15'd0};   // add R3,R1,R2
    want_bus  = '{32'h100000, 32'h80000, 32'h200000, 32'h2, 32'h4, 32'h80000};

    // Hand-computed pins on the model itself.
    build(add_ir, 0);
    check_lit("add_len", seq.size(), 6);
    for (int i = 0; i < 6; i++) check_lit($sformatf("add_bus_%0d", i), seq[i].bus_sel, want_bus[i]);
    check_lit("add_gpr", {16'h0, seq[5].gpr_in}, 32'h8);
    build(32'h802B0000, 0);
    check_lit("mul_len", seq.size(), 7);
    check_lit("mul_t5", {seq[5].bus_sel[30:0], seq[5].lo_in}, {31'h80000, 1'b1});
    check_lit("mul_t6", {seq[6].bus_sel[29:0], seq[6].hi_in, seq[6].done}, {30'h40000, 2'b11});
    build(32'h93A00000, 0);
    check_lit("not_t3", {seq[3].bus_sel[30:0], seq[3].y_in}, 32'h0);
    check_lit("not_t4", {seq[4].bus_sel[26:0], seq[4].alu_op}, {27'h10, 5'h12});
    check_lit("not_t5", {16'h0, seq[5].gpr_in}, 32'h80);
    build(add_ir, 3);
    check_lit("wait_len", seq.size(), 9);
    check_lit("wait_t1", {seq[3].pc_in, seq[3].mdr_in, seq[4].pc_in, seq[4].mdr_in, seq[4].read},
              32'b00111);
    build(32'hF8000000, 0);
    check_lit("ill_t3", {seq[3].done, seq[3].illegal, seq[3].bus_sel[29:0]}, {2'b11, 30'h0});

    // Reset held for two cycles, then directed sequences.
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    run_instr(add_ir, 0, 1'b0, -1);
    run_instr(32'h802B0000, 0, 1'b0, -1);
    run_instr(add_ir, 3, 1'b0, -1);
    run_instr(32'h93A00000, 0, 1'b0, -1);
    run_instr(32'hF8000000, 0, 1'b0, -1);
    run_instr(add_ir, 0, 1'b1, -1);        // start held high while busy and at done
    run_instr(add_ir, 0, 1'b0, 4);         // reset during T4
    run_instr(32'h802B0000, 3, 1'b0, 2);   // reset during a T1 memory wait

    for (int n = 0; n < 60; n++) begin
      if ($urandom % 6 == 0) begin
        do op = 5'($urandom_range(0, 31));
        while (op inside {[5'd3:5'd11], 5'd15, 5'd16, 5'd17, 5'd18});
      end else begin
        op = legal_ops[$urandom_range(0, 12)];
      end
      run_instr({op, 27'($urandom)}, $urandom_range(0, 3), 1'($urandom % 2),
                ($urandom % 6 == 0) ? $urandom_range(0, 8) : -1);
    end

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
